pad_voice_scheduler: RTL and testbench

Polyphonic playback scheduler for the drum-kit audio path. It takes pad triggers, runs up to NUM_VOICES concurrent voices over regions of one shared sample ROM, and time-multiplexes the ROM's single read port among the voices. It sums the fetched samples with saturation and pushes one mixed sample per frame into the audio controller's output FIFO. It sits between the pad/switch logic and the ROM/Audio_Controller pair, and replaces the single-sample player.

---
 rtl/pad_voice_scheduler.sv | 154 +++++++++++++++
 tb/tb_pad_voice_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_voice_scheduler.sv
// Polyphonic drum-pad scheduler: time-multiplexes one shared sample ROM among
// up to NUM_VOICES voices and writes one saturated mixed sample per frame.
module pad_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 12,
    parameter int SAMPLE_W   = 32,
    parameter int ROM_LAT    = 2
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic [NUM_VOICES-1:0]          trigger,
    input  logic [NUM_VOICES*ADDR_W-1:0]   start_addr,
    input  logic [NUM_VOICES*ADDR_W-1:0]   end_addr,
    output logic [ADDR_W-1:0]              rom_address,
    input  logic [SAMPLE_W-1:0]            rom_q,
    input  logic                           audio_out_allowed,
    output logic                           write_audio_out,
    output logic [SAMPLE_W-1:0]            left_channel_audio_out,
    output logic [SAMPLE_W-1:0]            right_channel_audio_out,
    output logic [NUM_VOICES-1:0]          active
);
    localparam int ACC_W = SAMPLE_W + 3;
    localparam int SEL_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_SAT, S_WRITE} state_t;
    state_t r_state, w_state_next;

    logic [NUM_VOICES-1:0]     r_trigger_d, r_pending, r_active, r_last, r_scan;
    logic [ADDR_W-1:0]         r_ptr [NUM_VOICES];
    logic [ROM_LAT-1:0]        r_vpipe;
    logic signed [ACC_W-1:0]   r_acc;
    logic [ADDR_W-1:0]         r_rom_address;
    logic [SAMPLE_W-1:0]       r_sample;

    logic [NUM_VOICES-1:0]     w_rise, w_start, w_active_next, w_scan_rest;
    logic [ADDR_W-1:0]         w_start_a [NUM_VOICES];
    logic [ADDR_W-1:0]         w_end_a [NUM_VOICES];
    logic [SEL_W-1:0]          w_sel_idx;
    logic [ROM_LAT-1:0]        w_vpipe_shift;
    logic                      w_issue, w_pipe_out;
    logic signed [ACC_W-1:0]   w_rom_sext;
    logic [SAMPLE_W-1:0]       w_sat;

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_start_a[v] = start_addr[v*ADDR_W +: ADDR_W];
            w_end_a[v]   = end_addr[v*ADDR_W +: ADDR_W];
        end
    end

    // Pending triggers with an empty region (start > end) are dropped at IDLE.
    always_comb begin
        w_start = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_start[v] = r_pending[v] && (w_start_a[v] <= w_end_a[v]);
        end
    end

    always_comb begin
        w_sel_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_scan[v]) w_sel_idx = SEL_W'(v);
        end
    end

    assign w_rise        = trigger & ~r_trigger_d;
    assign w_active_next = r_active | w_start;
    assign w_scan_rest   = r_scan & (r_scan - 1'b1);
    assign w_issue       = (r_state == S_ISSUE);
    assign w_pipe_out    = r_vpipe[ROM_LAT-1];
    assign w_vpipe_shift = r_vpipe << 1;
    assign w_rom_sext    = $signed({{3{rom_q[SAMPLE_W-1]}}, rom_q});

    // Clamp only when the guard bits disagree with the sample sign bit.
    assign w_sat = ((r_acc[ACC_W-1:SAMPLE_W-1] == '0) || (r_acc[ACC_W-1:SAMPLE_W-1] == '1))
                   ? r_acc[SAMPLE_W-1:0]
                   : (r_acc[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                     : {1'b0, {(SAMPLE_W-1){1'b1}}});

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (|w_active_next) w_state_next = S_ISSUE;
            S_ISSUE: if (w_scan_rest == '0) w_state_next = S_DRAIN;
            S_DRAIN: if (w_vpipe_shift == '0) w_state_next = S_SAT;
            S_SAT:   w_state_next = S_WRITE;
            S_WRITE: if (audio_out_allowed) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_trigger_d   <= '0;
            r_pending     <= '0;
            r_active      <= '0;
            r_last        <= '0;
            r_scan        <= '0;
            r_vpipe       <= '0;
            r_acc         <= '0;
            r_rom_address <= '0;
            r_sample      <= '0;
            for (int v = 0; v < NUM_VOICES; v++) r_ptr[v] <= '0;
        end else begin
            r_trigger_d <= trigger;
            r_vpipe[0]  <= w_issue;
            for (int i = 1; i < ROM_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
            // Returning ROM words can overlap the tail of ISSUE when A > ROM_LAT.
            if (w_pipe_out) r_acc <= r_acc + w_rom_sext;

            if (r_state == S_IDLE) r_pending <= w_rise;
            else                   r_pending <= r_pending | w_rise;

            case (r_state)
                S_IDLE: begin
                    r_acc    <= '0;
                    r_active <= w_active_next;
                    r_scan   <= w_active_next;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (w_start[v]) begin
                            r_ptr[v]  <= w_start_a[v];
                            r_last[v] <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_rom_address <= r_ptr[w_sel_idx];
                    r_scan        <= w_scan_rest;
                    if (r_ptr[w_sel_idx] == w_end_a[w_sel_idx]) r_last[w_sel_idx] <= 1'b1;
                    else r_ptr[w_sel_idx] <= r_ptr[w_sel_idx] + ADDR_W'(1);
                end
                S_SAT: r_sample <= w_sat;
                S_WRITE: begin
                    if (audio_out_allowed) begin
                        r_active <= r_active & ~r_last;
                        r_last   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign write_audio_out         = (r_state == S_WRITE) && audio_out_allowed;
    assign rom_address             = r_rom_address;
    assign left_channel_audio_out  = r_sample;
    assign right_channel_audio_out = r_sample;
    assign active                  = r_active;
endmodule

// File: tb/tb_pad_voice_scheduler.sv
// Directed bench for pad_voice_scheduler: table of mix vectors plus hand-written
// sequences for single-voice playback, retrigger, invalid region, backpressure and reset.
module tb_pad_voice_scheduler;
    localparam int NV = 4;
    localparam int AW = 12;
    localparam int SW = 32;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NV-1:0]     trigger;
    logic [NV*AW-1:0]  start_addr;
    logic [NV*AW-1:0]  end_addr;
    logic [AW-1:0]     rom_address;
    logic [SW-1:0]     rom_q;
    logic              audio_out_allowed;
    logic              write_audio_out;
    logic [SW-1:0]     left_channel_audio_out;
    logic [SW-1:0]     right_channel_audio_out;
    logic [NV-1:0]     active;

    pad_voice_scheduler #(.NUM_VOICES(NV), .ADDR_W(AW), .SAMPLE_W(SW), .ROM_LAT(2)) dut (
        .CLOCK_50(clk),
        .resetn(resetn),
        .trigger(trigger),
        .start_addr(start_addr),
        .end_addr(end_addr),
        .rom_address(rom_address),
        .rom_q(rom_q),
        .audio_out_allowed(audio_out_allowed),
        .write_audio_out(write_audio_out),
        .left_channel_audio_out(left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .active(active)
    );

    // Clock, cycle counter and ROM model (registered address + registered read).
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [SW-1:0] rom_mem [4096];
    always @(posedge clk) rom_q <= rom_mem[rom_address];

    // Scoreboard
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] mon_e;
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_writes = 0;
    int   last_wcyc = 0;
    logic prev_w = 1'b0;

    always begin
        @(negedge clk);
        #3;
        if (write_audio_out) begin
            n_writes++;
            last_wcyc = cyc;
            n_vec++;
            if (prev_w) begin
                n_fail++;
                $display("FAIL strobe_consecutive: strobe high on back-to-back cycles at cyc %0d", cyc);
            end
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got %08h, no write expected (cyc %0d)",
                         left_channel_audio_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (left_channel_audio_out !== mon_e || right_channel_audio_out !== mon_e) begin
                    n_fail++;
                    $display("FAIL write_value: got L=%08h R=%08h, want %08h (cyc %0d)",
                             left_channel_audio_out, right_channel_audio_out, mon_e, cyc);
                end
            end
        end
        prev_w = write_audio_out;
    end

    // Driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic set_region(input int v, input int s, input int e);
        start_addr[v*AW +: AW] = AW'(s);
        end_addr[v*AW +: AW]   = AW'(e);
    endtask

    task automatic pulse(input logic [NV-1:0] mask, output int tc);
        trigger = mask;
        tc = cyc;
        step();
        trigger = '0;
    endtask

    task automatic wait_write(output int wc);
        int n0;
        n0 = n_writes;
        wc = -1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (n_writes != n0) begin
                wc = last_wcyc;
                return;
            end
        end
        n_vec++;
        n_fail++;
        $display("FAIL write_timeout: no write within 80 cycles (cyc %0d)", cyc);
    endtask

    // Mix vector table
    typedef struct packed {
        logic [NV-1:0]         mask;
        logic [NV-1:0][SW-1:0] val;
        logic [SW-1:0]         exp;
    } vec_t;
    vec_t vecs[$];

    function automatic void add_vec(logic [NV-1:0] m, logic [SW-1:0] a, logic [SW-1:0] b,
                                    logic [SW-1:0] c, logic [SW-1:0] d, logic [SW-1:0] e);
        vec_t x;
        x.mask   = m;
        x.val[0] = a;
        x.val[1] = b;
        x.val[2] = c;
        x.val[3] = d;
        x.exp    = e;
        vecs.push_back(x);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int tc, wc, prev, n0, cr;

        add_vec(4'b1111, 32'd5, 32'hFFFF_FFFD, 32'd7, 32'd1, 32'd10);
        add_vec(4'b1111, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFFF);
        add_vec(4'b1111, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        add_vec(4'b0001, 32'd123, 32'd0, 32'd0, 32'd0, 32'd123);
        add_vec(4'b0101, 32'd100, 32'd9, 32'hFFFF_FED4, 32'd9, 32'hFFFF_FF38);
        add_vec(4'b1010, 32'd9, 32'h4000_0000, 32'd9, 32'h4000_0000, 32'h7FFF_FFFF);
        add_vec(4'b0110, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFE);
        add_vec(4'b1111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
        add_vec(4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h8000_0000);

        for (int i = 0; i < 4096; i++) rom_mem[i] = SW'(i);
        resetn = 1'b0;
        trigger = '0;
        start_addr = '0;
        end_addr = '0;
        audio_out_allowed = 1'b1;

        // Reset and idle
        repeat (3) step();
        check("rst_rom_address", rom_address, 0);
        check("rst_write", write_audio_out, 0);
        check("rst_left", left_channel_audio_out, 0);
        check("rst_right", right_channel_audio_out, 0);
        check("rst_active", active, 0);
        resetn = 1'b1;
        repeat (100) step();
        check("idle_writes", n_writes, 0);
        check("idle_left", left_channel_audio_out, 0);
        check("idle_active", active, 0);

        // Single voice 10..13 over ROM[i]=i
        set_region(0, 10, 13);
        for (int i = 10; i <= 13; i++) exp_q.push_back(SW'(i));
        pulse(4'b0001, tc);
        wait_write(wc);
        check("single_first_lat", wc, tc + 6);
        prev = wc;
        for (int k = 1; k < 4; k++) begin
            check($sformatf("single_active_%0d", k), active[0], 1);
            wait_write(wc);
            check($sformatf("single_spacing_%0d", k), wc - prev, 6);
            prev = wc;
        end
        check("single_active_end", active, 0);

        // Table-driven mix and saturation
        for (int v = 0; v < NV; v++) set_region(v, 100 + v, 100 + v);
        foreach (vecs[i]) begin
            for (int v = 0; v < NV; v++) rom_mem[100 + v] = vecs[i].val[v];
            exp_q.push_back(vecs[i].exp);
            pulse(vecs[i].mask, tc);
            wait_write(wc);
            check($sformatf("vec%0d_lat", i), wc, tc + 5 + $countones(vecs[i].mask));
            check($sformatf("vec%0d_active", i), active, 0);
        end

        // Retrigger voice 1 mid-play
        set_region(1, 200, 209);
        for (int i = 0; i < 10; i++) rom_mem[200 + i] = SW'(1000 + i);
        for (int i = 0; i < 4; i++) exp_q.push_back(SW'(1000 + i));
        for (int i = 0; i < 10; i++) exp_q.push_back(SW'(1000 + i));
        pulse(4'b0010, tc);
        wait_write(wc);
        check("retrig_first_lat", wc, tc + 6);
        prev = wc;
        for (int k = 1; k < 14; k++) begin
            if (k == 3) pulse(4'b0010, tc);
            wait_write(wc);
            check($sformatf("retrig_spacing_%0d", k), wc - prev, 6);
            prev = wc;
        end
        check("retrig_active_end", active, 0);

        // Empty region on voice 2 alongside a valid voice 0
        set_region(2, 20, 19);
        set_region(0, 10, 10);
        exp_q.push_back(SW'(10));
        pulse(4'b0101, tc);
        step();
        check("invalid_active", active, 4'b0001);
        wait_write(wc);
        check("invalid_lat", wc, tc + 6);
        check("invalid_active_end", active, 0);

        // Backpressure at WRITE
        set_region(0, 10, 11);
        exp_q.push_back(SW'(10));
        exp_q.push_back(SW'(11));
        audio_out_allowed = 1'b0;
        n0 = n_writes;
        pulse(4'b0001, tc);
        repeat (50) step();
        check("bp_no_write", n_writes, n0);
        check("bp_left_held", left_channel_audio_out, 10);
        check("bp_right_held", right_channel_audio_out, 10);
        check("bp_strobe_low", write_audio_out, 0);
        audio_out_allowed = 1'b1;
        cr = cyc;
        wait_write(wc);
        check("bp_release_write", wc, cr);
        wait_write(wc);
        check("bp_next_frame", wc, cr + 6);
        check("bp_active_end", active, 0);

        // Async reset during DRAIN
        set_region(0, 10, 13);
        pulse(4'b0001, tc);
        step();
        step();
        check("rst_mid_active_before", active, 4'b0001);
        n0 = n_writes;
        resetn = 1'b0;
        #1;
        check("rst_mid_write", write_audio_out, 0);
        check("rst_mid_active", active, 0);
        check("rst_mid_left", left_channel_audio_out, 0);
        check("rst_mid_rom_address", rom_address, 0);
        repeat (3) step();
        resetn = 1'b1;
        repeat (30) step();
        check("rst_mid_no_write", n_writes, n0);
        check("rst_mid_active_after", active, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
